// File: rtl/alu_tmr_scrub_ctrl.sv
// rtl/alu_tmr_scrub_ctrl.sv - TMR ALU controller: bus arbitration, idle-cycle scrubber, voter, replica masking
module alu_tmr_scrub_ctrl #(
   parameter int          SCRUB_PERIOD = 64,
   parameter int          THRESH       = 3,
   parameter int          CW           = 4,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_dp_req,
   input  logic [31:0] i_dp_a,
   input  logic [31:0] i_dp_b,
   input  logic [2:0]  i_dp_cont,
   output logic        o_dp_gnt,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   output logic [2:0]  o_alu_cont,
   input  logic [31:0] i_r0,
   input  logic [31:0] i_r1,
   input  logic [31:0] i_r2,
   input  logic        i_z0,
   input  logic        i_z1,
   input  logic        i_z2,
   output logic [31:0] o_vote_res,
   output logic        o_vote_zero,
   output logic [2:0]  o_mask,
   output logic        o_uncorr,
   output logic        o_degraded,
   output logic        o_scrub_done
);

   localparam int              TW         = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
   localparam logic [TW-1:0]   TIMER_LOAD = TW'(SCRUB_PERIOD - 1);
   localparam logic [CW-1:0]   CNT_THR    = CW'(THRESH);
   localparam logic [CW-1:0]   CNT_MAX    = {CW{1'b1}};
   localparam logic [31:0]     LFSR_TAPS  = 32'h0040_0007;

   typedef enum logic [1:0] {
      S_COUNT = 2'd0,
      S_ISSUE = 2'd1,
      S_EVAL  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TW-1:0]   r_timer;
   logic [TW-1:0]   w_timer_nxt;
   logic            w_advance;
   logic [31:0]     r_lfsr;
   logic [2:0]      r_idx;
   logic [2:0]      w_op;
   logic            w_vote_act;

   logic [32:0]     w_v [3];
   logic [32:0]     w_maj;
   logic [32:0]     w_vote;
   logic            w_nomaj;
   logic            w_eq01;
   logic            w_eq02;
   logic            w_eq12;
   logic [2:0]      w_dis;
   logic [2:0]      w_cross;
   logic            w_multi;
   logic [2:0]      w_mask_nxt;
   logic [CW-1:0]   r_cnt [3];
   logic [CW-1:0]   w_cnt_nxt [3];
   logic [2:0]      r_mask;
   logic            r_uncorr;
   logic            r_degraded;
   logic            r_scrub_done;

   always_comb begin
      case (r_idx)
         3'd0:    w_op = 3'b010;
         3'd1:    w_op = 3'b110;
         3'd2:    w_op = 3'b000;
         3'd3:    w_op = 3'b001;
         default: w_op = 3'b111;
      endcase
   end

   // Datapath always wins the bus; the scrub vector only appears on idle ISSUE cycles.
   assign o_dp_gnt   = i_dp_req;
   assign w_vote_act = i_dp_req | (r_state == S_ISSUE);

   always_comb begin
      o_alu_a    = 32'd0;
      o_alu_b    = 32'd0;
      o_alu_cont = 3'b000;
      if (i_dp_req) begin
         o_alu_a    = i_dp_a;
         o_alu_b    = i_dp_b;
         o_alu_cont = i_dp_cont;
      end else if (r_state == S_ISSUE) begin
         o_alu_a    = r_lfsr;
         o_alu_b    = ~r_lfsr;
         o_alu_cont = w_op;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_advance   = 1'b0;
      case (r_state)
         S_COUNT: begin
            if (!i_dp_req) begin
               if (r_timer == '0) w_state_nxt = S_ISSUE;
               else               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_ISSUE: begin
            if (!i_dp_req) w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            w_state_nxt = S_COUNT;
            w_timer_nxt = TIMER_LOAD;
            w_advance   = 1'b1;
         end
         default: w_state_nxt = S_COUNT;
      endcase
   end

   assign w_v[0] = {i_r0, i_z0};
   assign w_v[1] = {i_r1, i_z1};
   assign w_v[2] = {i_r2, i_z2};
   assign w_maj  = (w_v[0] & w_v[1]) | (w_v[0] & w_v[2]) | (w_v[1] & w_v[2]);
   assign w_eq01 = (w_v[0] == w_v[1]);
   assign w_eq02 = (w_v[0] == w_v[2]);
   assign w_eq12 = (w_v[1] == w_v[2]);

   // On no majority the lowest-index enabled replica is forwarded.
   always_comb begin
      w_vote  = w_maj;
      w_nomaj = 1'b0;
      case (r_mask)
         3'b111: begin
            if (!w_eq01 && !w_eq02 && !w_eq12) begin
               w_nomaj = 1'b1;
               w_vote  = w_v[0];
            end
         end
         3'b011: begin w_vote = w_v[0]; w_nomaj = ~w_eq01; end
         3'b101: begin w_vote = w_v[0]; w_nomaj = ~w_eq02; end
         3'b110: begin w_vote = w_v[1]; w_nomaj = ~w_eq12; end
         3'b001: w_vote = w_v[0];
         3'b010: w_vote = w_v[1];
         3'b100: w_vote = w_v[2];
         default: w_vote = w_v[0];
      endcase
   end

   assign o_vote_res  = w_vote[32:1];
   assign o_vote_zero = w_vote[0];

   always_comb begin
      w_dis   = 3'b000;
      w_cross = 3'b000;
      for (int i = 0; i < 3; i++) begin
         w_dis[i]     = w_vote_act & ~w_nomaj & r_mask[i] & (w_v[i] != w_vote);
         w_cnt_nxt[i] = r_cnt[i];
         if (w_dis[i] && (r_cnt[i] != CNT_MAX)) w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         w_cross[i]   = w_dis[i] & (w_cnt_nxt[i] >= CNT_THR);
      end
   end

   // Only one replica may drop per edge, and never the last one standing.
   assign w_multi = (r_mask[0] & r_mask[1]) | (r_mask[0] & r_mask[2]) | (r_mask[1] & r_mask[2]);

   always_comb begin
      w_mask_nxt = r_mask;
      if (w_multi) begin
         if      (w_cross[0]) w_mask_nxt[0] = 1'b0;
         else if (w_cross[1]) w_mask_nxt[1] = 1'b0;
         else if (w_cross[2]) w_mask_nxt[2] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_COUNT;
         r_timer      <= TIMER_LOAD;
         r_lfsr       <= LFSR_SEED;
         r_idx        <= 3'd0;
         r_mask       <= 3'b111;
         r_uncorr     <= 1'b0;
         r_degraded   <= 1'b0;
         r_scrub_done <= 1'b0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_mask       <= w_mask_nxt;
         r_uncorr     <= w_vote_act & w_nomaj;
         r_degraded   <= ~&w_mask_nxt;
         r_scrub_done <= (w_state_nxt == S_EVAL);
         for (int i = 0; i < 3; i++) r_cnt[i] <= w_cnt_nxt[i];
         if (w_advance) begin
            r_lfsr <= {r_lfsr[30:0], 1'b0} ^ ({32{r_lfsr[31]}} & LFSR_TAPS);
            r_idx  <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
         end
      end
   end

   assign o_mask       = r_mask;
   assign o_uncorr     = r_uncorr;
   assign o_degraded   = r_degraded;
   assign o_scrub_done = r_scrub_done;

endmodule

// File: tb/tb_alu_tmr_scrub_ctrl.sv
// tb/tb_alu_tmr_scrub_ctrl.sv - self-checking bench for alu_tmr_scrub_ctrl
`timescale 1ns/1ps
module tb_alu_tmr_scrub_ctrl;

   localparam int          SP   = 64;
   localparam int          TH   = 3;
   localparam int          CW   = 4;
   localparam logic [31:0] SEED = 32'hACE1_0001;
   localparam int          PH_WAIT  = 0;
   localparam int          PH_ISSUE = 1;
   localparam int          PH_EVAL  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        dp_req;
   logic [31:0] dp_a, dp_b;
   logic [2:0]  dp_cont;
   logic        dp_gnt;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_cont;
   logic [31:0] r0, r1, r2;
   logic        z0, z1, z2;
   logic [31:0] vote_res;
   logic        vote_zero;
   logic [2:0]  mask;
   logic        uncorr, degraded, scrub_done;
   logic [31:0] f0, f1, f2;

   always #5 clk = ~clk;

   alu_tmr_scrub_ctrl #(.SCRUB_PERIOD(SP), .THRESH(TH), .CW(CW), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset(reset),
      .i_dp_req(dp_req), .i_dp_a(dp_a), .i_dp_b(dp_b), .i_dp_cont(dp_cont),
      .o_dp_gnt(dp_gnt), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cont(alu_cont),
      .i_r0(r0), .i_r1(r1), .i_r2(r2), .i_z0(z0), .i_z1(z1), .i_z2(z2),
      .o_vote_res(vote_res), .o_vote_zero(vote_zero), .o_mask(mask),
      .o_uncorr(uncorr), .o_degraded(degraded), .o_scrub_done(scrub_done)
   );

   function automatic logic [31:0] rep_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      case (c)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a ^ b;
      endcase
   endfunction

   // Replicas: a shared ALU function with a per-replica XOR fault pattern.
   always_comb begin
      r0 = rep_fn(alu_a, alu_b, alu_cont) ^ f0;
      r1 = rep_fn(alu_a, alu_b, alu_cont) ^ f1;
      r2 = rep_fn(alu_a, alu_b, alu_cont) ^ f2;
      z0 = (r0 == 32'd0);
      z1 = (r1 == 32'd0);
      z2 = (r2 == 32'd0);
   end

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      logic [32:0] t;
      t = {l, 1'b0};
      if (t[32]) t = t ^ 33'h1_0040_0007;
      return t[31:0];
   endfunction

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [2:0]  ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
   int          m_countdown, m_phase, m_idx;
   logic [31:0] m_lfsr;
   int          m_cnt [3];
   logic [2:0]  m_mask;
   logic        m_uncorr;

   task automatic model_reset();
      m_countdown = SP;
      m_phase     = PH_WAIT;
      m_idx       = 0;
      m_lfsr      = SEED;
      m_mask      = 3'b111;
      m_uncorr    = 1'b0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; dp_req = 1'b0; dp_a = '0; dp_b = '0; dp_cont = '0;
      f0 = '0; f1 = '0; f2 = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One lockstep cycle against the reference model; inputs are already applied.
   task automatic model_cycle();
      logic [31:0] ea, eb, res;
      logic [2:0]  ec;
      logic        act, nomaj, found;
      logic [32:0] val [3];
      logic [32:0] vote;
      int          en_q [$];
      int          victim;
      #1;
      ea = '0; eb = '0; ec = '0;
      if (dp_req) begin
         ea = dp_a; eb = dp_b; ec = dp_cont;
      end else if (m_phase == PH_ISSUE) begin
         ea = m_lfsr; eb = ~m_lfsr; ec = ops[m_idx];
      end
      check("gnt", dp_gnt, dp_req);
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
      check("alu_cont", alu_cont, ec);
      check("mask", mask, m_mask);
      check("uncorr", uncorr, m_uncorr);
      check("degraded", degraded, m_mask != 3'b111);
      check("scrub_done", scrub_done, m_phase == PH_EVAL);
      act = dp_req || (m_phase == PH_ISSUE);
      for (int i = 0; i < 3; i++) begin
         res = rep_fn(ea, eb, ec) ^ ((i == 0) ? f0 : (i == 1) ? f1 : f2);
         val[i] = {res, res == 32'd0};
         if (m_mask[i]) en_q.push_back(i);
      end
      found = 1'b0;
      vote  = val[en_q[0]];
      for (int p = 0; p < en_q.size(); p++)
         for (int q = p + 1; q < en_q.size(); q++)
            if (!found && val[en_q[p]] == val[en_q[q]]) begin
               found = 1'b1;
               vote  = val[en_q[p]];
            end
      nomaj = (en_q.size() > 1) && !found;
      if (act) begin
         check("vote_res", vote_res, vote[32:1]);
         check("vote_zero", vote_zero, vote[0]);
      end
      m_uncorr = act && nomaj;
      victim = -1;
      if (act && !nomaj)
         for (int i = 0; i < 3; i++)
            if (m_mask[i] && val[i] != vote) begin
               if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
               if (m_cnt[i] >= TH && victim < 0) victim = i;
            end
      if (victim >= 0 && en_q.size() > 1) m_mask[victim] = 1'b0;
      if (m_phase == PH_WAIT) begin
         if (!dp_req) begin
            m_countdown--;
            if (m_countdown == 0) m_phase = PH_ISSUE;
         end
      end else if (m_phase == PH_ISSUE) begin
         if (!dp_req) m_phase = PH_EVAL;
      end else begin
         m_lfsr      = lfsr_step(m_lfsr);
         m_idx       = (m_idx + 1) % 5;
         m_countdown = SP;
         m_phase     = PH_WAIT;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic [2:0]  cont;
      logic [31:0] f0, f1, f2;
      logic [31:0] res;
      logic        zero;
      logic        uncorr;
      logic [2:0]  mask;
   } vec_t;

   vec_t        tbl [9];
   int          done_q [$];
   int          issue_q [$];
   logic [2:0]  cont_q [$];
   logic [31:0] a_q [$];
   logic [31:0] exp_l;
   logic [2:0]  exp_ops [6];

   initial begin
      tbl[0] = '{32'd5,         32'd7,         3'b010, 32'h0, 32'h0,         32'h0,  32'd12,        1'b0, 1'b0, 3'b111};
      tbl[1] = '{32'd9,         32'd9,         3'b110, 32'h0, 32'h1,         32'h0,  32'd0,         1'b1, 1'b0, 3'b111};
      tbl[2] = '{32'hF0F0_0000, 32'h0FF0_0000, 3'b000, 32'h10, 32'h10,       32'h0,  32'h00F0_0010, 1'b0, 1'b0, 3'b111};
      tbl[3] = '{32'd1,         32'd2,         3'b001, 32'h1, 32'h2,         32'h4,  32'd2,         1'b0, 1'b1, 3'b111};
      tbl[4] = '{32'hFFFF_FFFF, 32'd1,         3'b111, 32'h0, 32'h1,         32'h0,  32'd1,         1'b0, 1'b0, 3'b111};
      tbl[5] = '{32'd3,         32'd3,         3'b010, 32'h0, 32'h8000_0000, 32'h0,  32'd6,         1'b0, 1'b0, 3'b101};
      tbl[6] = '{32'd10,        32'd4,         3'b110, 32'h0, 32'hFF,        32'h0,  32'd6,         1'b0, 1'b0, 3'b101};
      tbl[7] = '{32'd7,         32'd8,         3'b010, 32'h0, 32'h0,         32'h1,  32'd15,        1'b0, 1'b1, 3'b101};
      tbl[8] = '{32'd0,         32'd0,         3'b000, 32'h0, 32'h0,         32'h0,  32'd0,         1'b1, 1'b0, 3'b101};
      exp_ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

      // Idle run from reset: scrub timing, op sequence and operand LFSR.
      do_reset();
      #1;
      check("reset_mask", mask, 3'b111);
      check("reset_uncorr", uncorr, 1'b0);
      check("reset_degraded", degraded, 1'b0);
      check("reset_done", scrub_done, 1'b0);
      @(negedge clk);
      for (int c = 1; c < 400; c++) begin
         #1;
         if (scrub_done) done_q.push_back(c);
         if (alu_a != 32'd0) begin
            issue_q.push_back(c);
            cont_q.push_back(alu_cont);
            a_q.push_back(alu_a);
         end
         @(negedge clk);
      end
      check("t1_done_count", done_q.size(), 6);
      check("t1_issue_count", cont_q.size(), 6);
      if (done_q.size() > 0)  check("t1_first_done_cycle", done_q[0], SP + 1);
      if (issue_q.size() > 0) check("t1_first_issue_cycle", issue_q[0], SP);
      exp_l = SEED;
      for (int k = 0; k < 6 && k < cont_q.size(); k++) begin
         check("t1_op_seq", cont_q[k], exp_ops[k]);
         check("t1_lfsr_seq", a_q[k], exp_l);
         exp_l = lfsr_step(exp_l);
      end
      check("t1_mask", mask, 3'b111);

      // Async reset in the middle of the 7th ISSUE cycle.
      repeat (60) @(negedge clk);
      #1;
      check("t6_issue_cont", alu_cont, 3'b110);
      check("t6_issue_a", alu_a, exp_l);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_alu_a", alu_a, 32'd0);
      check("t6_rst_alu_cont", alu_cont, 3'b000);
      check("t6_rst_done", scrub_done, 1'b0);
      check("t6_rst_mask", mask, 3'b111);
      dp_req = 1'b1; dp_a = 32'h1234_5678;
      #1;
      check("t6_rst_gnt", dp_gnt, 1'b1);
      check("t6_rst_dp_a", alu_a, 32'h1234_5678);
      dp_req = 1'b0; dp_a = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (SP) @(negedge clk);
      #1;
      check("t6_restart_a", alu_a, SEED);
      check("t6_restart_cont", alu_cont, 3'b010);
      @(negedge clk);

      // Datapath preempts the ISSUE cycle for five cycles.
      do_reset();
      repeat (SP) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         dp_req = 1'b1; dp_a = $urandom; dp_b = $urandom; dp_cont = 3'($urandom_range(0, 7));
         #1;
         check("t2_gnt", dp_gnt, 1'b1);
         check("t2_alu_a", alu_a, dp_a);
         check("t2_alu_b", alu_b, dp_b);
         check("t2_alu_cont", alu_cont, dp_cont);
         check("t2_no_done", scrub_done, 1'b0);
         @(negedge clk);
      end
      dp_req = 1'b0;
      #1;
      check("t2_issue_a", alu_a, SEED);
      check("t2_issue_cont", alu_cont, 3'b010);
      check("t2_issue_gnt", dp_gnt, 1'b0);
      check("t2_issue_done", scrub_done, 1'b0);
      @(negedge clk);
      #1;
      check("t2_done", scrub_done, 1'b1);
      @(negedge clk);

      // Vector table: voting, disagreement counting, masking, no-majority.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         dp_req = 1'b1; dp_a = tbl[k].a; dp_b = tbl[k].b; dp_cont = tbl[k].cont;
         f0 = tbl[k].f0; f1 = tbl[k].f1; f2 = tbl[k].f2;
         #1;
         check("tbl_gnt", dp_gnt, 1'b1);
         check("tbl_alu_a", alu_a, tbl[k].a);
         check("tbl_vote_res", vote_res, tbl[k].res);
         check("tbl_vote_zero", vote_zero, tbl[k].zero);
         @(posedge clk);
         #1;
         check("tbl_mask", mask, tbl[k].mask);
         check("tbl_degraded", degraded, tbl[k].mask != 3'b111);
         check("tbl_uncorr", uncorr, tbl[k].uncorr);
         @(negedge clk);
      end

      // With r1 masked, repeated r2 faults flag uncorrectable but never empty the mask.
      for (int k = 0; k < 10; k++) begin
         dp_req = 1'b1; dp_a = $urandom; dp_b = $urandom; dp_cont = 3'($urandom_range(0, 7));
         f0 = '0; f1 = $urandom; f2 = $urandom | 32'h1;
         #1;
         check("t5_vote_r0", vote_res, rep_fn(dp_a, dp_b, dp_cont));
         @(posedge clk);
         #1;
         check("t5_uncorr", uncorr, 1'b1);
         check("t5_mask", mask, 3'b101);
         @(negedge clk);
      end
      dp_req = 1'b0; f0 = '0; f1 = '0; f2 = '0;
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_mask", mask, 3'b111);
      check("t6_async_degraded", degraded, 1'b0);
      check("t6_async_uncorr", uncorr, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Randomized episodes against the reference model.
      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         for (int c = 0; c < 400; c++) begin
            dp_req  = ($urandom_range(0, 9) < 3);
            dp_a    = $urandom;
            dp_b    = (ep[0] && $urandom_range(0, 3) == 0) ? dp_a : $urandom;
            dp_cont = 3'($urandom_range(0, 7));
            f0 = '0; f1 = '0; f2 = '0;
            if ($urandom_range(0, 11) == 0) begin
               case ($urandom_range(0, 7))
                  0, 1: f0 = $urandom | 32'h1;
                  2, 3: f1 = $urandom | 32'h1;
                  4:    f2 = $urandom | 32'h1;
                  5:    begin f0 = 32'h4; f2 = 32'h4; end
                  6:    begin f1 = 32'h1; f2 = 32'h2; end
                  default: begin f0 = 32'h1; f1 = 32'h2; f2 = 32'h4; end
               endcase
            end
            model_cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
